// File: rtl/barrel_sweep_ctrl_if.sv
// rtl/barrel_sweep_ctrl_if.sv - word input and result output handshakes of barrel_sweep_ctrl
interface barrel_sweep_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int SHW   = 2
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [SHW-1:0]   out_amt;
  logic             out_last;

  // Word producer and result consumer side
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_amt, out_last
  );

  // Sweep controller side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_amt, out_last
  );
endinterface

// File: rtl/barrel_sweep_ctrl.sv
// rtl/barrel_sweep_ctrl.sv - sweeps one accepted word through every rotate amount of barrel_shifter
module barrel_sweep_ctrl #(
  parameter int WIDTH = 4,
  parameter int SHW   = 2
) (
  input  logic               clk,
  input  logic               rst,
  barrel_sweep_ctrl_if.slave bus,
  output logic [WIDTH-1:0]   sh_in,
  output logic [SHW-1:0]     sh_amt,
  input  logic [WIDTH-1:0]   sh_out,
  output logic               busy,
  output logic [7:0]         words_done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [SHW-1:0] K_LAST = SHW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] word_q;
  logic [SHW-1:0]   k;

  // word_q and k are cleared on the way back to IDLE, so the shifter sees zeros while idle
  assign sh_in  = word_q;
  assign sh_amt = k;

  // Sweep sequencer: accept a word, then sample/hold one result per shift amount
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      word_q        <= '0;
      k             <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_amt   <= '0;
      bus.out_last  <= 1'b0;
      busy          <= 1'b0;
      words_done    <= 8'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            word_q       <= bus.in_data;
            k            <= '0;
            bus.in_ready <= 1'b0;
            busy         <= 1'b1;
            state        <= SAMPLE;
          end
        end
        SAMPLE: begin
          bus.out_data  <= sh_out;
          bus.out_amt   <= k;
          bus.out_last  <= (k == K_LAST);
          bus.out_valid <= 1'b1;
          state         <= HOLD;
        end
        HOLD: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            if (bus.out_last) begin
              if (words_done != 8'hFF) begin
                words_done <= words_done + 8'd1;
              end
              word_q       <= '0;
              k            <= '0;
              bus.in_ready <= 1'b1;
              busy         <= 1'b0;
              state        <= IDLE;
            end else begin
              k     <= k + 1'b1;
              state <= SAMPLE;
            end
          end
        end
        default: begin
          word_q        <= '0;
          k             <= '0;
          bus.in_ready  <= 1'b1;
          bus.out_valid <= 1'b0;
          busy          <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_barrel_sweep_ctrl.sv
// tb/tb_barrel_sweep_ctrl.sv - vector, directed and randomized checks of barrel_sweep_ctrl
module tb_barrel_sweep_ctrl;
  localparam int W = 4;
  localparam int S = 2;

  typedef logic [3:0][3:0] quad_t;
  typedef struct {
    logic [3:0] d;
    quad_t      e;
    int         stall_amt;
    int         stall_len;
  } vec_t;
  typedef struct {
    logic [3:0] d;
    int         a;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] sh_in;
  logic [W-1:0] sh_out;
  logic [S-1:0] sh_amt;
  logic         busy;
  logic [7:0]   words_done;

  int   total = 0;
  int   bad = 0;
  int   model_done = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  exp_t mon_p;

  vec_t       vecs[6];
  logic [3:0] rd;
  int         rs, rl, n, words, accepted, run, idle_run, guard;

  barrel_sweep_ctrl_if #(.WIDTH(W), .SHW(S)) bus ();

  barrel_sweep_ctrl #(.WIDTH(W), .SHW(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .sh_in      (sh_in),
    .sh_amt     (sh_amt),
    .sh_out     (sh_out),
    .busy       (busy),
    .words_done (words_done)
  );

  always #5 clk = ~clk;

  // Stand-in for barrel_shifter: input bit i lands on bit (i + amt) mod W
  always_comb begin
    sh_out = '0;
    for (int i = 0; i < W; i++) begin
      sh_out[S'((i + int'(sh_amt)) % W)] = sh_in[i];
    end
  end

  function automatic void chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Rotate-left as plain arithmetic on the word value
  function automatic logic [3:0] ref_rot(input logic [3:0] d, input int a);
    int v;
    int r;
    v = int'(d);
    r = (v * (2 ** a)) % 16 + v / (2 ** (4 - a));
    return 4'(r);
  endfunction

  function automatic quad_t ref_quad(input logic [3:0] d);
    quad_t q;
    for (int a = 0; a < 4; a++) q[a] = ref_rot(d, a);
    return q;
  endfunction

  function automatic quad_t q4(input logic [3:0] e0, input logic [3:0] e1,
                               input logic [3:0] e2, input logic [3:0] e3);
    quad_t q;
    q[0] = e0; q[1] = e1; q[2] = e2; q[3] = e3;
    return q;
  endfunction

  // Scoreboard: every accepted word owes four results in amount order
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      model_done = 0;
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        for (int a = 0; a < 4; a++) begin
          mon_p.d = ref_rot(bus.in_data, a);
          mon_p.a = a;
          exp_q.push_back(mon_p);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("mon_unexpected_result", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("mon_data", bus.out_data, mon_e.d);
          chk("mon_amt", bus.out_amt, mon_e.a);
          chk("mon_last", bus.out_last, (mon_e.a == 3) ? 1 : 0);
          if (mon_e.a == 3 && model_done < 255) model_done++;
        end
      end
    end
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_data"}, bus.out_data, 0);
    chk({tag, "_out_amt"}, bus.out_amt, 0);
    chk({tag, "_out_last"}, bus.out_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_words_done"}, words_done, 0);
    chk({tag, "_sh_in"}, sh_in, 0);
    chk({tag, "_sh_amt"}, sh_amt, 0);
  endtask

  task automatic pulse_reset(input string tag);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk_reset_state(tag);
    @(negedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] d);
    int c;
    c = 0;
    @(posedge clk); #1;
    while (!bus.in_ready && c < 40) begin
      @(posedge clk); #1;
      c++;
    end
    chk("accept_wait", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("busy_after_accept", busy, 1);
  endtask

  task automatic collect(input quad_t e, input int stall_amt, input int stall_len);
    int c;
    for (int a = 0; a < 4; a++) begin
      if (a == stall_amt) begin
        if (a > 0) begin
          @(posedge clk); #1;
        end
        bus.out_ready = 1'b0;
      end
      c = 0;
      do begin
        @(negedge clk);
        c++;
      end while (!bus.out_valid && c < 20);
      chk("result_gap", c, 2);
      chk("out_data", bus.out_data, e[a]);
      chk("out_amt", bus.out_amt, a);
      chk("out_last", bus.out_last, (a == 3) ? 1 : 0);
      chk("in_ready_in_sweep", bus.in_ready, 0);
      if (a == stall_amt) begin
        repeat (stall_len) begin
          @(negedge clk);
          chk("hold_valid", bus.out_valid, 1);
          chk("hold_data", bus.out_data, e[a]);
          chk("hold_amt", bus.out_amt, a);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(posedge clk);
      end
    end
  endtask

  task automatic idle_check(input string tag);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_words_done"}, words_done, model_done);
    chk({tag, "_sh_in"}, sh_in, 0);
    chk({tag, "_sh_amt"}, sh_amt, 0);
  endtask

  initial begin
    vecs[0] = '{d: 4'b1101, e: q4(4'b1101, 4'b1011, 4'b0111, 4'b1110), stall_amt: -1, stall_len: 0};
    vecs[1] = '{d: 4'b1010, e: q4(4'b1010, 4'b0101, 4'b1010, 4'b0101), stall_amt: 1,  stall_len: 5};
    vecs[2] = '{d: 4'b0011, e: q4(4'b0011, 4'b0110, 4'b1100, 4'b1001), stall_amt: -1, stall_len: 0};
    vecs[3] = '{d: 4'b1000, e: q4(4'b1000, 4'b0001, 4'b0010, 4'b0100), stall_amt: 3,  stall_len: 2};
    vecs[4] = '{d: 4'b0000, e: q4(4'b0000, 4'b0000, 4'b0000, 4'b0000), stall_amt: 0,  stall_len: 3};
    vecs[5] = '{d: 4'b1111, e: q4(4'b1111, 4'b1111, 4'b1111, 4'b1111), stall_amt: -1, stall_len: 0};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    @(negedge clk);
    chk_reset_state("init");
    #1 rst = 1'b0;

    // Reset pulsed mid-clock while a sweep is running
    send_word(4'b0110);
    repeat (3) @(posedge clk);
    pulse_reset("midsweep");

    // Table vectors, including held results under backpressure
    for (int i = 0; i < 6; i++) begin
      send_word(vecs[i].d);
      collect(vecs[i].e, vecs[i].stall_amt, vecs[i].stall_len);
      idle_check("vec");
    end

    // Second word offered throughout a sweep waits for IDLE
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_data  = 4'b0101;
    @(posedge clk); #1;
    bus.in_data  = 4'b0011;
    collect(q4(4'b0101, 4'b1010, 4'b0101, 4'b1010), -1, 0);
    @(posedge clk); #1;
    chk("held_word_ready_after_sweep", bus.in_ready, 1);
    chk("held_word_idle", busy, 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("held_word_accepted", busy, 1);
    collect(vecs[2].e, -1, 0);
    idle_check("held_word");

    // Reset while holding the amount-2 result
    send_word(4'b0110);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.out_valid && bus.out_amt == 2'd1) && n < 20);
    chk("abort_reach_amt1", bus.out_amt, 1);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 20);
    chk("abort_hold_amt2", bus.out_amt, 2);
    pulse_reset("abort");
    bus.out_ready = 1'b1;
    send_word(4'b0110);
    collect(ref_quad(4'b0110), -1, 0);
    idle_check("after_abort");
    chk("after_abort_count", words_done, 1);

    // Randomized words and stalls against the reference model
    for (int i = 0; i < 20; i++) begin
      rd = 4'($urandom);
      rs = $urandom_range(0, 4);
      rl = $urandom_range(0, 4);
      send_word(rd);
      collect(ref_quad(rd), (rs == 4) ? -1 : rs, rl);
      idle_check("rand");
    end

    // 256 back-to-back words: cycle budget per word and saturation
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    accepted = 0; words = 0; run = 0; idle_run = 0; guard = 0;
    while (words < 256 && guard < 4000) begin
      @(posedge clk); #1;
      bus.in_data = 4'($urandom);
      if (accepted >= 256) bus.in_valid = 1'b0;
      @(negedge clk);
      guard++;
      if (bus.in_valid && bus.in_ready) accepted++;
      if (busy) begin
        if (idle_run != 0) begin
          if (words > 0) chk("b2b_idle_cycles", idle_run, 1);
          idle_run = 0;
        end
        run++;
      end else begin
        if (run != 0) begin
          chk("b2b_busy_cycles", run, 8);
          chk("b2b_in_ready", bus.in_ready, 1);
          chk("b2b_words_done", words_done, model_done);
          words++;
        end
        run = 0;
        idle_run++;
      end
    end
    bus.in_valid = 1'b0;
    chk("b2b_all_words", words, 256);
    idle_check("b2b_end");
    chk("b2b_saturated", words_done, 8'hFF);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
